// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
// Shares one line-memory port between an instruction cache (i_*) and a data
// cache (d_*). One transaction is in flight at a time; on a tie the cache that
// was not granted last wins. The op, address and wdata of the granted request
// are captured at grant time and drive the memory port until mem_resp.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_read/i_write/i_address/i_wdata  I-cache request (read+write => write)
//   i_rdata/i_resp             I-cache return line and completion pulse
//   d_read/d_write/d_address/d_wdata  D-cache request (read+write => write)
//   d_rdata/d_resp             D-cache return line and completion pulse
//   mem_read/mem_write/mem_address/mem_wdata  shared memory request
//   mem_rdata/mem_resp         shared memory return line and completion pulse
module cacheline_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction cache
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  // Round-robin history: 1 means the last completed grant went to D.
  logic              r_last_d;

  // Captured request of the current owner.
  logic              r_op_write;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_busy;
  logic              w_done;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_address;
  logic [LINE_W-1:0] w_sel_wdata;

  assign w_req_i = i_read | i_write;
  assign w_req_d = d_read | d_write;
  assign w_busy  = (r_state == BUSY_I) || (r_state == BUSY_D);
  // mem_resp only counts while a transaction is outstanding.
  assign w_done  = w_busy && mem_resp;

  // Next-state and grant decision.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        // D wins when alone, or on a tie when I was not... rather when D was
        // not the last one served.
        if (w_req_d && (!w_req_i || !r_last_d)) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (w_req_i) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request mux feeding the capture registers; a write wins over a read.
  always_comb begin
    w_sel_write   = i_write;
    w_sel_address = i_address;
    w_sel_wdata   = i_wdata;
    if (w_grant_d) begin
      w_sel_write   = d_write;
      w_sel_address = d_address;
      w_sel_wdata   = d_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture registers, loaded only on a grant so they hold through BUSY and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_write <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
    end else if (w_grant_i || w_grant_d) begin
      r_op_write <= w_sel_write;
      r_address  <= w_sel_address;
      r_wdata    <= w_sel_wdata;
    end
  end

  // Fairness history advances when a transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_done) begin
      r_last_d <= (r_state == BUSY_D);
    end
  end

  // Memory port is a pure decode of registered state.
  assign mem_read    = w_busy && !r_op_write;
  assign mem_write   = w_busy &&  r_op_write;
  assign mem_address = r_address;
  assign mem_wdata   = r_wdata;

  // Return path: data broadcast to both caches, only resp is steered.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = (r_state == BUSY_I) && mem_resp;
  assign d_resp  = (r_state == BUSY_D) && mem_resp;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: expected memory transactions are
// queued as requests are driven and compared as the memory port presents them.
module tb_cacheline_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] i_wdata, d_wdata;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              i_resp, d_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_address  (i_address),
    .i_wdata    (i_wdata),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push(input bit is_d, input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] dat);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.data = dat;
    sb.push_back(e);
  endtask

  // Acts as the memory: waits for a request, checks it against the scoreboard
  // for every busy cycle, returns rdata after lat extra cycles, checks the
  // steered resp and the following idle bubble. drop releases the owner's request.
  task automatic serve(input int lat, input bit drop, input logic [LINE_W-1:0] rdata);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) seen = 1'b1;
    end
    if (!seen) begin
      check("grant_timeout", LINE_W'(0), LINE_W'(1));
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", LINE_W'(0), LINE_W'(1));
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      check("busy_mem_write", LINE_W'(mem_write), LINE_W'(e.wr));
      check("busy_mem_read",  LINE_W'(mem_read),  LINE_W'(!e.wr));
      check("busy_mem_addr",  LINE_W'(mem_address), LINE_W'(e.addr));
      check("busy_mem_wdata", mem_wdata, e.data);
      check("busy_no_resp",   LINE_W'({i_resp, d_resp}), LINE_W'(0));
    end
    @(posedge clk);
    #1;
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    if (drop) begin
      if (e.is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else        begin i_read = 1'b0; i_write = 1'b0; end
    end
    @(negedge clk);
    check("resp_mem_write", LINE_W'(mem_write), LINE_W'(e.wr));
    check("resp_mem_addr",  LINE_W'(mem_address), LINE_W'(e.addr));
    check("resp_i_resp",    LINE_W'(i_resp), LINE_W'(!e.is_d));
    check("resp_d_resp",    LINE_W'(d_resp), LINE_W'(e.is_d));
    check("resp_i_rdata",   i_rdata, rdata);
    check("resp_d_rdata",   d_rdata, rdata);
    @(posedge clk);
    #1;
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    @(negedge clk);
    check("bubble_mem_op",  LINE_W'({mem_read, mem_write}), LINE_W'(0));
    check("bubble_resp",    LINE_W'({i_resp, d_resp}), LINE_W'(0));
    check("bubble_addr",    LINE_W'(mem_address), LINE_W'(e.addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] dw;
    logic [LINE_W-1:0] pat;
    bit                seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    {i_read, i_write, d_read, d_write} = 4'b0;
    i_address = '0; d_address = '0;
    i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_op", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    check("rst_resp",   LINE_W'({i_resp, d_resp}), LINE_W'(0));
    check("rst_addr",   LINE_W'(mem_address), LINE_W'(0));
    check("rst_wdata",  mem_wdata, LINE_W'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie after reset: D first, then I.
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h100; i_wdata = rand_line();
    d_read = 1'b1; d_address = 32'h200; d_wdata = rand_line();
    push(1'b1, 1'b0, 32'h200, d_wdata);
    push(1'b0, 1'b0, 32'h100, i_wdata);
    serve(2, 1'b1, rand_line());
    serve(1, 1'b1, rand_line());

    // Single D write; requester address changes mid-transaction.
    @(posedge clk); #1;
    dw = {32{8'hA5}};
    d_write = 1'b1; d_address = 32'h40; d_wdata = dw;
    push(1'b1, 1'b1, 32'h40, dw);
    fork
      serve(4, 1'b1, rand_line());
      begin
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        d_address = 32'h80;
        d_wdata   = rand_line();
      end
    join

    // Read+write together on I is a write; rdata pattern returned.
    @(posedge clk); #1;
    pat = {8{32'hDEADBEEF}};
    i_read = 1'b1; i_write = 1'b1; i_address = 32'h500; i_wdata = rand_line();
    push(1'b0, 1'b1, 32'h500, i_wdata);
    serve(1, 1'b1, pat);

    // Fairness: both request continuously; last grant was I so D goes first.
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h1000; i_wdata = rand_line();
    d_write = 1'b1; d_address = 32'h2000; d_wdata = rand_line();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(1'b1, 1'b1, 32'h2000, d_wdata);
      else            push(1'b0, 1'b0, 32'h1000, i_wdata);
    end
    for (int k = 0; k < 6; k++) serve(k % 3, k >= 4, rand_line());

    // Reset mid-transaction during BUSY_I, then a stray mem_resp.
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h300; i_wdata = rand_line();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    check("midrst_busy", LINE_W'(seen), LINE_W'(1));
    rst_n = 1'b0;
    i_read = 1'b0;
    #1;
    check("midrst_mem_op", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    check("midrst_resp",   LINE_W'({i_resp, d_resp}), LINE_W'(0));
    check("midrst_addr",   LINE_W'(mem_address), LINE_W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b1;
    @(negedge clk);
    check("stray_resp",   LINE_W'({i_resp, d_resp}), LINE_W'(0));
    check("stray_mem_op", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    @(posedge clk); #1 mem_resp = 1'b0;

    // After reset, history is cleared: a tie goes to D again.
    @(posedge clk); #1;
    i_write = 1'b1; i_address = 32'h700; i_wdata = rand_line();
    d_read  = 1'b1; d_address = 32'h800; d_wdata = rand_line();
    push(1'b1, 1'b0, 32'h800, d_wdata);
    push(1'b0, 1'b1, 32'h700, i_wdata);
    serve(0, 1'b1, rand_line());
    serve(2, 1'b1, rand_line());

    check("sb_drained", LINE_W'(sb.size()), LINE_W'(0));
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
